match_window_counter: RTL and testbench

MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

---
 rtl/match_window_counter_if.sv | 34 +++
 rtl/match_window_counter.sv | 147 ++++++++++++++
 tb/tb_match_window_counter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/match_window_counter_if.sv
// Handshake bundle between the match window counter and its consumer.
// Optional peak_count signal present when MATCH_WINDOW_COUNTER_PEAK_EN is defined.
interface match_window_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             det;
    logic             out_ready;
    logic             out_valid;
    logic [CNT_W-1:0] count_out;
    logic             sat;
    logic             drop;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
    logic [CNT_W-1:0] peak_count;

    modport master (
        output enable, det, out_ready,
        input  out_valid, count_out, sat, drop, peak_count
    );
    modport slave (
        input  enable, det, out_ready,
        output out_valid, count_out, sat, drop, peak_count
    );
`else
    modport master (
        output enable, det, out_ready,
        input  out_valid, count_out, sat, drop
    );
    modport slave (
        input  enable, det, out_ready,
        output out_valid, count_out, sat, drop
    );
`endif
endinterface

// File: rtl/match_window_counter.sv
// Counts detector matches over back-to-back fixed windows and hands each result to a
// valid/ready consumer. Define MATCH_WINDOW_COUNTER_PEAK_EN to add the peak_count output.
module match_window_counter #(
    parameter int unsigned WINDOW = 64,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    match_window_counter_if.slave bus
);
    localparam int unsigned       TMR_W    = $clog2(WINDOW);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             drop_q, drop_d;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;
`endif

    logic             acc_full;
    logic [CNT_W-1:0] fin_cnt;
    logic             fin_sat;
    logic             load;

    // Running count including this cycle's det, clamped at CNT_MAX
    always_comb begin
        acc_full = (acc_q == CNT_MAX);
        fin_cnt  = acc_full ? CNT_MAX : acc_q + CNT_W'(bus.det);
        fin_sat  = acc_sat_q | (bus.det & acc_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            drop_q    <= 1'b0;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
            peak_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            drop_q    <= drop_d;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
            peak_q    <= peak_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        valid_d   = valid_q;
        count_d   = count_q;
        sat_d     = sat_q;
        drop_d    = drop_q;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
        peak_d    = peak_q;
`endif
        load      = 1'b0;

        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                acc_d     = '0;
                acc_sat_d = 1'b0;
                if (bus.enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (timer_q == TMR_LAST) begin
                    // A held result not taken this cycle wins; the new one is lost
                    timer_d   = '0;
                    acc_d     = '0;
                    acc_sat_d = 1'b0;
                    if (!valid_q || bus.out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    if (!bus.enable) begin
                        state_d = IDLE;
                    end
                end else if (!bus.enable) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    acc_d     = '0;
                    acc_sat_d = 1'b0;
                end else begin
                    timer_d   = timer_q + TMR_W'(1);
                    acc_d     = fin_cnt;
                    acc_sat_d = fin_sat;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            valid_d = 1'b1;
            count_d = fin_cnt;
            sat_d   = fin_sat;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
            peak_d  = (fin_cnt > peak_q) ? fin_cnt : peak_q;
`endif
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.count_out  = count_q;
    assign bus.sat        = sat_q;
    assign bus.drop       = drop_q;
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
    assign bus.peak_count = peak_q;
`endif

endmodule

// File: tb/tb_match_window_counter.sv
// Scoreboard bench: two counters (CNT_W=4 and CNT_W=2, WINDOW=8) share one stimulus stream
// and are checked against a window-level integer model. Honours MATCH_WINDOW_COUNTER_PEAK_EN.
module tb_match_window_counter;
    localparam int WINDOW = 8;
    localparam int MAX0   = 15;
    localparam int MAX1   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic enable, det, out_ready;

    always #5 clk = ~clk;

    match_window_counter_if #(.CNT_W(4)) if0();
    match_window_counter_if #(.CNT_W(2)) if1();

    assign if0.enable    = enable;
    assign if0.det       = det;
    assign if0.out_ready = out_ready;
    assign if1.enable    = enable;
    assign if1.det       = det;
    assign if1.out_ready = out_ready;

    match_window_counter #(.WINDOW(WINDOW), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(if0.slave)
    );
    match_window_counter #(.WINDOW(WINDOW), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(if1.slave)
    );

    typedef struct {
        int tot;
        int pk0;
        int pk1;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: window position, raw match total, result slot occupancy
    bit m_run, m_hold, m_drop;
    int m_pos, m_cnt, m_pk0, m_pk1;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   consume;
        int   tot;
        if (!rst_n) begin
            m_run = 0; m_hold = 0; m_drop = 0;
            m_pos = 0; m_cnt = 0; m_pk0 = 0; m_pk1 = 0;
            exp_q.delete();
        end else begin
            consume = m_hold && out_ready;
            if (m_run && m_pos == WINDOW - 1) begin
                tot = m_cnt + int'(det);
                if (!m_hold || out_ready) begin
                    m_pk0 = max_i(m_pk0, min_i(tot, MAX0));
                    m_pk1 = max_i(m_pk1, min_i(tot, MAX1));
                    e.tot = tot; e.pk0 = m_pk0; e.pk1 = m_pk1;
                    exp_q.push_back(e);
                    m_hold = 1;
                end else begin
                    m_drop = 1;
                end
                m_pos = 0; m_cnt = 0;
                m_run = enable;
            end else begin
                if (consume) m_hold = 0;
                if (m_run && enable) begin
                    m_cnt = m_cnt + int'(det);
                    m_pos = m_pos + 1;
                end else begin
                    m_pos = 0; m_cnt = 0;
                    m_run = enable;
                end
            end
        end
    end

    // Monitor: compares presented results on handshake, plus per-cycle status
    bit prev_stall = 0;
    int prev_c0, prev_s0, prev_c1, prev_s1;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("valid0", int'(if0.out_valid), int'(m_hold));
            chk("valid1", int'(if1.out_valid), int'(m_hold));
            chk("drop0", int'(if0.drop), int'(m_drop));
            chk("drop1", int'(if1.drop), int'(m_drop));
            if (prev_stall) begin
                chk("stable_cnt0", int'(if0.count_out), prev_c0);
                chk("stable_sat0", int'(if0.sat), prev_s0);
                chk("stable_cnt1", int'(if1.count_out), prev_c1);
                chk("stable_sat1", int'(if1.sat), prev_s1);
            end
            if (if0.out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("count0", int'(if0.count_out), min_i(e.tot, MAX0));
                    chk("sat0", int'(if0.sat), int'(e.tot > MAX0));
                    chk("count1", int'(if1.count_out), min_i(e.tot, MAX1));
                    chk("sat1", int'(if1.sat), int'(e.tot > MAX1));
`ifdef MATCH_WINDOW_COUNTER_PEAK_EN
                    chk("peak0", int'(if0.peak_count), e.pk0);
                    chk("peak1", int'(if1.peak_count), e.pk1);
`endif
                end
            end
            prev_stall = if0.out_valid && !out_ready;
            prev_c0 = int'(if0.count_out); prev_s0 = int'(if0.sat);
            prev_c1 = int'(if1.count_out); prev_s1 = int'(if1.sat);
        end else begin
            prev_stall = 0;
        end
    end

    task automatic step(input bit en, input bit d, input bit rdy);
        @(posedge clk);
        #1;
        enable = en; det = d; out_ready = rdy;
    endtask

    // One IDLE cycle then a full window with det taken from mask bit i in window cycle i
    task automatic run_window(input logic [7:0] mask);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < WINDOW; i++) step(1'b1, mask[i], 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(if0.out_valid) + int'(if1.out_valid), 0);
        chk({tag, "_count"}, int'(if0.count_out) + int'(if1.count_out), 0);
        chk({tag, "_sat"}, int'(if0.sat) + int'(if1.sat), 0);
        chk({tag, "_drop"}, int'(if0.drop) + int'(if1.drop), 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; det = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Matches in window cycles 1, 3, 7
        run_window(8'b1000_1010);
        chk("w137_valid", int'(if0.out_valid), 1);
        chk("w137_count", int'(if0.count_out), 3);
        chk("w137_sat", int'(if0.sat), 0);

        // Continuous matches: narrow counter saturates without wrapping
        for (int i = 0; i < 4 * WINDOW; i++) step(1'b1, 1'b1, 1'b1);
        chk("satw_count1", int'(if1.count_out), 3);
        chk("satw_sat1", int'(if1.sat), 1);
        chk("satw_count0", int'(if0.count_out), 8);
        chk("satw_sat0", int'(if0.sat), 0);

        // Back-pressure across several window ends
        for (int i = 0; i < 3 * WINDOW; i++) step(1'b1, 1'b1, 1'b0);
        chk("bp_count", int'(if0.count_out), 8);
        chk("bp_valid", int'(if0.out_valid), 1);
        chk("bp_drop", int'(if0.drop), 1);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Abort a window at timer=4 after two matches, then a fresh window
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (WINDOW + 2) step(1'b0, 1'b1, 1'b1);
        chk("abort_novalid", int'(if0.out_valid), 0);
        run_window(8'b0010_0000);
        chk("reen_count", int'(if0.count_out), 1);
        chk("reen_valid", int'(if0.out_valid), 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0, 1'($urandom), $urandom_range(0, 3) != 0);

        // Asynchronous reset mid-window while holding a result
        repeat (WINDOW + 2) step(1'b0, 1'b0, 1'b1);
        repeat (WINDOW + 4) step(1'b1, 1'b1, 1'b0);
        chk("prerst_valid", int'(if0.out_valid), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 1) != 0);

        repeat (WINDOW + 4) step(1'b0, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
